simon_iter_ctrl: RTL and testbench
==================================

Name: simon_iter_ctrl

Overview:
Iterative sequencer for SIMON 64/96. It holds a key-expansion engine, a 42-entry round-key register file and one round-function datapath, and reuses that round datapath once per cycle. It sits between the UART rx-FIFO read side and the tx-FIFO write side and replaces the purely combinational cipher path. Valid/ready handshakes on both sides let the FIFOs apply backpressure.

Parameters:
ROUNDS, 42, rounds per block (fixed by SIMON 64/96)
WORD_W, 32, half-block word width
KEY_WORDS, 3, key words (m) in the key schedule

Ports:
clk_100MHz  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_in  input  96  master key; {k2,k1,k0}, k0 = key_in[31:0]
key_load  input  1  one-cycle pulse; starts key expansion from key_in
key_ready  output  1  round keys are valid
in_valid  input  1  input block offered
in_ready  output  1  controller accepts a block
in_data  input  64  block; x = [63:32], y = [31:0]
in_decrypt  input  1  sampled with in_data; 1 = decrypt, 0 = encrypt
out_valid  output  1  result is available
out_ready  input  1  downstream accepts the result
out_data  output  64  result; same word order as in_data
busy  output  1  state is KEYEXP or RUN

Behaviour:
- Reset (asynchronous): state = IDLE; key_ready, in_ready, out_valid and busy = 0; out_data = 0; round counter = 0; key file is don't-care.
- IDLE: waits for key_load, then goes to KEYEXP. in_valid is ignored and in_ready stays 0.
- KEYEXP:
  - Load k0..k2 from key_in on the key_load cycle.
  - Compute one key per cycle for i = 0..38: t = ROR3(k[i+2]); t ^= ROR1(t); k[i+3] = ~k[i] ^ t ^ z2[i mod 62] ^ 3.
  - This takes 39 cycles, then the state goes to READY and key_ready = 1.
- READY:
  - in_ready = 1.
  - On in_valid & in_ready: latch x, y and dir, set rnd = 0 (encrypt) or 41 (decrypt), go to RUN. in_ready drops on the next cycle.
- RUN: one round per cycle, with f(a) = (ROL1 a & ROL8 a) ^ ROL2 a.
  - Encrypt: (x, y) <= (y ^ f(x) ^ k[rnd], x); rnd increments.
  - Decrypt: (x, y) <= (y, x ^ f(y) ^ k[rnd]); rnd decrements.
  - After exactly 42 rounds, go to DONE.
- DONE:
  - out_valid = 1 and out_data = {x, y}, both held stable until out_ready.
  - On out_valid & out_ready: go to READY and drop out_valid on the next cycle.
- Latency: out_valid rises 43 cycles after the accept cycle. Minimum issue interval is 44 cycles with out_ready tied high.
- Rotations are within 32-bit words. The round counter is 6 bits and never wraps outside 0..41.
- key_load in any non-IDLE state:
  - Discard any in-flight or pending output: out_valid drops next cycle and no partial result is emitted.
  - Clear key_ready and restart KEYEXP with the new key.
- key_load on the same cycle as an accept: key_load wins and the block is not accepted (in_ready is gated off when key_load = 1).
- in_valid while key_ready = 0: no accept, block remains in the upstream FIFO.
- in_decrypt is captured only at accept; changes during RUN have no effect.
- Reset mid-RUN or mid-KEYEXP: immediate return to IDLE; the key must be reloaded.
- All outputs are registered except in_ready, which is a decode of state and key_load.

Decomposition:
- Package simon_pkg:
  - ROUNDS, WORD_W, KEY_WORDS
  - Z2 62-bit constant (SIMON z2 sequence)
  - round constant C = 32'hFFFFFFFC
  - state enum {IDLE, KEYEXP, READY, RUN, DONE}
  - f() and rotate functions
- Sub-module simon_key_expand: the key-register file plus the expansion counter.
  - Interface: key_in, key_load, rd_idx, rd_key, done.
  - simon_iter_ctrl keeps the block FSM and the round datapath.

Test Plan:
- Encrypt KAT: key_load with key 0x131211100b0a090803020100, wait for key_ready (39 cycles), in_data 0x6f7220676e696c63 with in_decrypt = 0 -> out_data 0x5ca2e27f111a8fc8, out_valid exactly 43 cycles after accept.
- Decrypt KAT: same key, in_data 0x5ca2e27f111a8fc8 with in_decrypt = 1 -> out_data 0x6f7220676e696c63.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid -> out_data stable, in_ready = 0 throughout, one transfer on release, in_ready = 1 next cycle.
- Early input: in_valid = 1 before any key_load -> in_ready stays 0 and no output; after key_load + 39 cycles the block is accepted.
- Abort: key_load pulse at round 20 of a run -> out_valid never asserts for that block, key_ready drops, re-expands, and the next block encrypts correctly under the new key.
- Reset at round 10 -> all outputs 0 on the same edge, state IDLE; a subsequent in_valid is not accepted until a key is reloaded.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants, state encoding and word-level helpers for the SIMON 64/96
// iterative cipher.
package simon_pkg;
  localparam int ROUNDS    = 42;
  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 3;

  // z2 written in sequence order: z2[i] lives at bit 61-i.
  localparam logic [61:0] Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  localparam logic [WORD_W-1:0] C = 32'hFFFFFFFC;

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, RUN, DONE} state_t;

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] a, input int s);
    return (a << s) | (a >> (WORD_W - s));
  endfunction

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] a, input int s);
    return (a >> s) | (a << (WORD_W - s));
  endfunction

  function automatic logic [WORD_W-1:0] f(input logic [WORD_W-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

  function automatic logic z2_bit(input logic [5:0] i);
    return Z2[6'd61 - i];
  endfunction
endpackage

// File: rtl/simon_key_expand.sv
// Round-key register file plus the one-key-per-cycle expansion engine.
// done is high during the final expansion step so the owner can register it.
module simon_key_expand
  import simon_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_WORDS*WORD_W-1:0]   key_in,
  input  logic                          key_load,
  input  logic [5:0]                    rd_idx,
  output logic [WORD_W-1:0]             rd_key,
  output logic                          done
);
  localparam int STEPS = ROUNDS - KEY_WORDS;

  logic [WORD_W-1:0] kf [ROUNDS];
  logic [5:0]        cnt;
  logic              run;
  logic [WORD_W-1:0] t, nk;

  always_comb begin
    t  = ror(kf[cnt + 6'd2], 3);
    t  = t ^ ror(t, 1);
    nk = kf[cnt] ^ C ^ t ^ {{(WORD_W-1){1'b0}}, z2_bit(cnt)};
  end

  // Key storage carries no reset; it is rewritten by every key_load.
  always_ff @(posedge clk) begin
    if (key_load) begin
      for (int i = 0; i < KEY_WORDS; i++) kf[i] <= key_in[i*WORD_W +: WORD_W];
    end else if (run) begin
      kf[cnt + 6'd3] <= nk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (key_load) begin
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == 6'(STEPS-1)) run <= 1'b0;
      else                    cnt <= cnt + 6'd1;
    end
  end

  assign done   = run && (cnt == 6'(STEPS-1));
  assign rd_key = kf[rd_idx];
endmodule

// File: rtl/simon_iter_ctrl.sv
// SIMON 64/96 block sequencer: key expansion, then one round per cycle
// between a valid/ready input port and a valid/ready output port.
module simon_iter_ctrl
  import simon_pkg::*;
(
  input  logic                        clk_100MHz,
  input  logic                        reset,
  input  logic [KEY_WORDS*WORD_W-1:0] key_in,
  input  logic                        key_load,
  output logic                        key_ready,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*WORD_W-1:0]         in_data,
  input  logic                        in_decrypt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*WORD_W-1:0]         out_data,
  output logic                        busy
);
  state_t            state;
  logic [WORD_W-1:0] x, y, nx, ny, rk;
  logic [5:0]        rnd;
  logic              dir, kx_done, last;

  simon_key_expand u_kx (
    .clk      (clk_100MHz),
    .rst      (reset),
    .key_in   (key_in),
    .key_load (key_load),
    .rd_idx   (rnd),
    .rd_key   (rk),
    .done     (kx_done)
  );

  // key_load takes priority over an accept in the same cycle.
  assign in_ready = (state == READY) && !key_load;

  always_comb begin
    if (dir) begin
      nx = y;
      ny = x ^ f(y) ^ rk;
    end else begin
      nx = y ^ f(x) ^ rk;
      ny = x;
    end
  end

  assign last = dir ? (rnd == 6'd0) : (rnd == 6'(ROUNDS-1));

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      rnd       <= '0;
      x         <= '0;
      y         <= '0;
      dir       <= 1'b0;
    end else if (key_load) begin
      // Restart from any state; an in-flight or pending result is dropped.
      state     <= KEYEXP;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        KEYEXP: if (kx_done) begin
          state     <= READY;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
        READY: if (in_valid && in_ready) begin
          x     <= in_data[2*WORD_W-1:WORD_W];
          y     <= in_data[WORD_W-1:0];
          dir   <= in_decrypt;
          rnd   <= in_decrypt ? 6'(ROUNDS-1) : 6'd0;
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: begin
          x <= nx;
          y <= ny;
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= {nx, ny};
          end else begin
            rnd <= dir ? rnd - 6'd1 : rnd + 6'd1;
          end
        end
        DONE: if (out_ready) begin
          state     <= READY;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_iter_ctrl.sv
// Randomized self-checking bench for simon_iter_ctrl against a loop-level
// SIMON 64/96 reference model, plus the published test vector.
module tb_simon_iter_ctrl;
  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic [95:0] key_in     = '0;
  logic        key_load   = 1'b0;
  logic        key_ready;
  logic        in_valid   = 1'b0;
  logic        in_ready;
  logic [63:0] in_data    = '0;
  logic        in_decrypt = 1'b0;
  logic        out_valid;
  logic        out_ready  = 1'b1;
  logic [63:0] out_data;
  logic        busy;

  simon_iter_ctrl dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .key_in     (key_in),
    .key_load   (key_load),
    .key_ready  (key_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_decrypt (in_decrypt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: key list and cipher computed straight from the algorithm.
  logic [61:0] z2seq = 62'b10101111011100000011010010011000101000010001111110010110110011;
  logic [31:0] mk [42];

  function automatic logic [31:0] rotr(input logic [31:0] a, input int s);
    return (a >> s) | (a << (32 - s));
  endfunction
  function automatic logic [31:0] rotl(input logic [31:0] a, input int s);
    return (a << s) | (a >> (32 - s));
  endfunction
  function automatic logic [31:0] sf(input logic [31:0] a);
    return (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2);
  endfunction

  task automatic model_keys(input logic [95:0] key);
    logic [31:0] t;
    for (int i = 0; i < 3; i++) mk[i] = key[32*i +: 32];
    for (int i = 3; i < 42; i++) begin
      t = rotr(mk[i-1], 3);
      t = t ^ rotr(t, 1);
      mk[i] = 32'hFFFFFFFC ^ {31'd0, z2seq[61-(i-3)]} ^ mk[i-3] ^ t;
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] d, input bit dec);
    logic [31:0] a, b, t;
    a = d[63:32];
    b = d[31:0];
    for (int r = 0; r < 42; r++) begin
      if (!dec) begin t = a; a = b ^ sf(a) ^ mk[r];      b = t; end
      else      begin t = b; b = a ^ sf(b) ^ mk[41 - r]; a = t; end
    end
    return {a, b};
  endfunction

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic load_key(input logic [95:0] k, output int n);
    model_keys(k);
    key_in = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n = 0;
    while (!key_ready && n < 100) begin tick(); n++; end
  endtask

  task automatic offer(input logic [63:0] d, input bit dec, output bit acc);
    in_data = d; in_decrypt = dec; in_valid = 1'b1; acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_100MHz);
      if (in_ready) acc = 1'b1;
      tick();
    end
    // Scramble the inputs after accept; the run must ignore them.
    in_valid = 1'b0; in_data = {$urandom, $urandom}; in_decrypt = ~dec;
  endtask

  task automatic wait_out(output int lat, output logic [63:0] res);
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    res = out_data;
  endtask

  localparam logic [95:0] KAT_KEY = 96'h131211100b0a090803020100;
  localparam logic [63:0] KAT_PT  = 64'h6f7220676e696c63;
  localparam logic [63:0] KAT_CT  = 64'h5ca2e27f111a8fc8;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, lat;
    bit acc, bad;
    logic [63:0] res, d, held;
    logic [95:0] k;
    bit dec;

    tick(); tick();
    chk("rst_outs", {59'd0, key_ready, in_ready, out_valid, busy, 1'b0}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    reset = 1'b0;

    // Block offered before any key exists.
    in_data = KAT_PT; in_decrypt = 1'b0; in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_100MHz);
      if (in_ready || out_valid || key_ready) bad = 1'b1;
      tick();
    end
    chk("early_no_accept", bad, 1'b0);

    load_key(KAT_KEY, n);
    chk("keyexp_cycles", n, 39);
    chk("kat_model_self", model(KAT_PT, 1'b0), KAT_CT);
    offer(KAT_PT, 1'b0, acc);
    chk("kat_enc_accept", acc, 1'b1);
    chk("run_busy", busy, 1'b1);
    wait_out(lat, res);
    chk("kat_enc_latency", lat, 43);
    chk("kat_enc_data", res, KAT_CT);
    tick();
    chk("post_xfer_valid", out_valid, 1'b0);
    chk("post_xfer_ready", in_ready, 1'b1);

    // Decrypt with 20 cycles of output backpressure.
    out_ready = 1'b0;
    offer(KAT_CT, 1'b1, acc);
    wait_out(lat, res);
    chk("kat_dec_latency", lat, 43);
    chk("kat_dec_data", res, KAT_PT);
    held = res; bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!out_valid || out_data !== held || in_ready) bad = 1'b1;
    end
    chk("bp_hold", bad, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);

    // Random keys and blocks.
    for (int kk = 0; kk < 2; kk++) begin
      k = {$urandom, $urandom, $urandom};
      load_key(k, n);
      chk("rnd_keyexp", n, 39);
      for (int b = 0; b < 4; b++) begin
        d = {$urandom, $urandom};
        dec = 1'($urandom_range(0, 1));
        offer(d, dec, acc);
        wait_out(lat, res);
        chk("rnd_latency", lat, 43);
        chk(dec ? "rnd_dec" : "rnd_enc", res, model(d, dec));
        tick();
      end
    end

    // Abort at round 20 with a new key.
    offer(KAT_PT, 1'b0, acc);
    for (int i = 0; i < 19; i++) tick();
    k = {$urandom, $urandom, $urandom};
    model_keys(k);
    key_in = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("abort_key_ready", key_ready, 1'b0);
    bad = 1'b0; n = 0;
    while (!key_ready && n < 100) begin
      if (out_valid) bad = 1'b1;
      tick(); n++;
    end
    chk("abort_no_output", bad, 1'b0);
    chk("abort_rekey_cycles", n, 39);
    d = {$urandom, $urandom};
    offer(d, 1'b0, acc);
    wait_out(lat, res);
    chk("abort_next_enc", res, model(d, 1'b0));
    tick();

    // Asynchronous reset at round 10.
    offer(KAT_PT, 1'b0, acc);
    for (int i = 0; i < 9; i++) tick();
    #2 reset = 1'b1;
    #1;
    chk("areset_outs", {59'd0, key_ready, in_ready, out_valid, busy, 1'b0}, 64'd0);
    chk("areset_data", out_data, 64'd0);
    tick();
    reset = 1'b0;
    in_data = KAT_PT; in_decrypt = 1'b0; in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_100MHz);
      if (in_ready || out_valid) bad = 1'b1;
      tick();
    end
    chk("after_reset_no_accept", bad, 1'b0);
    load_key(KAT_KEY, n);
    offer(KAT_PT, 1'b0, acc);
    wait_out(lat, res);
    chk("after_reset_enc", res, KAT_CT);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
